// File: rtl/aes_pkg.sv
// Shared constants, types and GF(2^8) helper for the AES-128 accelerator.
package aes_pkg;

    localparam int MEM_WORDS = 1024;
    localparam int ADDR_W    = $clog2(MEM_WORDS);
    localparam int PT_BASE   = 0;
    localparam int KEY_BASE  = 4;
    localparam int CT_BASE   = 256;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_ENC  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_ROUND,
        ST_STORE,
        ST_DONE
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_dp_ram.sv
// True dual-port 32-bit word RAM: port A byte-write host port, port B word-wide engine port.
module aes_dp_ram
    import aes_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        a_we_i,
    input  logic [ADDR_W-1:0] a_wr_addr_i,
    input  logic [31:0]       a_wdata_i,
    input  logic [ADDR_W-1:0] a_rd_addr_i,
    output logic [31:0]       a_rdata_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [31:0]       b_wdata_i,
    output logic [31:0]       b_rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;

    // NOTE: the array has no reset; clearing 1024 words would defeat RAM inference.
    // Port B is written after port A so the engine's word wins a same-word collision.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (a_we_i[i]) begin
                mem_q[a_wr_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
            end
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // NOTE: non-blocking reads see the pre-write contents, giving read-old-data behaviour.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_rd_addr_i];
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/aes_accel_top.sv
// Memory-mapped iterative AES-128 encryptor: one round per cycle, key expanded on the fly.
module aes_accel_top
    import aes_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [2:0]        aes_ctrl_in,
    input  logic [31:0]       aes_data_in,
    input  logic [3:0]        aes_mem_we_in,
    input  logic [ADDR_W-1:0] aes_mem_rd_addr_in,
    input  logic [ADDR_W-1:0] aes_mem_wr_addr_in,
    output logic [31:0]       aes_data_out,
    output logic              aes_complete_out
);

    // Byte i of a 128-bit block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [127:0]      blk_q, blk_d;
    logic [127:0]      key_q, key_d;
    logic              complete_q, complete_d;

    logic [ADDR_W-1:0] eng_addr;
    logic              eng_we;
    logic [31:0]       eng_wdata;
    logic [31:0]       eng_rdata;

    logic [3:0]        load_idx;
    logic [3:0]        rcon_idx;
    logic [127:0]      rk_next;
    logic [127:0]      sr_out;
    logic [127:0]      round_out;

    aes_dp_ram u_ram (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .a_we_i      (aes_mem_we_in),
        .a_wr_addr_i (aes_mem_wr_addr_in),
        .a_wdata_i   (aes_data_in),
        .a_rd_addr_i (aes_mem_rd_addr_in),
        .a_rdata_o   (aes_data_out),
        .b_we_i      (eng_we),
        .b_addr_i    (eng_addr),
        .b_wdata_i   (eng_wdata),
        .b_rdata_o   (eng_rdata)
    );

    // Round counter runs 1..10 in ROUND; clamp so other states never index past RCON.
    assign rcon_idx  = (cnt_q == 4'd0 || cnt_q > 4'd10) ? 4'd0 : cnt_q - 4'd1;
    assign rk_next   = next_key(key_q, RCON[rcon_idx]);
    assign sr_out    = shift_rows(sub_bytes(blk_q));
    assign round_out = ((cnt_q == 4'd10) ? sr_out : mix_columns(sr_out)) ^ rk_next;
    assign load_idx  = cnt_q - 4'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            blk_q      <= '0;
            key_q      <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            key_q      <= key_d;
            complete_q <= complete_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        key_d      = key_q;
        complete_d = complete_q;
        eng_addr   = '0;
        eng_we     = 1'b0;
        eng_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (aes_ctrl_in == CMD_ENC) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Address issued in cycle n returns in cycle n+1, so capture lags by one.
                eng_addr = cnt_q[2] ? ADDR_W'(KEY_BASE) + ADDR_W'(cnt_q[1:0])
                                    : ADDR_W'(PT_BASE)  + ADDR_W'(cnt_q[1:0]);
                if (cnt_q != 4'd0) begin
                    if (load_idx[2]) key_d = {key_q[95:0], eng_rdata};
                    else             blk_d = {blk_q[95:0], eng_rdata};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                blk_d   = blk_q ^ key_q;
                cnt_d   = 4'd1;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                blk_d = round_out;
                key_d = rk_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    cnt_d   = '0;
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                eng_we    = 1'b1;
                eng_addr  = ADDR_W'(CT_BASE) + ADDR_W'(cnt_q[1:0]);
                eng_wdata = blk_q[127:96];
                blk_d     = {blk_q[95:0], blk_q[127:96]};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Raise complete on the first DONE cycle regardless of the command, then wait for ack.
                if (!complete_q) begin
                    complete_d = 1'b1;
                end else if (aes_ctrl_in == CMD_IDLE) begin
                    complete_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign aes_complete_out = complete_q;

endmodule

// File: tb/tb_aes_accel_top.sv
// Scoreboard bench for aes_accel_top: table-free AES reference model, decoupled read monitor.
module tb_aes_accel_top;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [2:0]  aes_ctrl_in;
    logic [31:0] aes_data_in;
    logic [3:0]  aes_mem_we_in;
    logic [9:0]  aes_mem_rd_addr_in;
    logic [9:0]  aes_mem_wr_addr_in;
    logic [31:0] aes_data_out;
    logic        aes_complete_out;

    always #5 clk_in = ~clk_in;

    aes_accel_top dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .aes_ctrl_in        (aes_ctrl_in),
        .aes_data_in        (aes_data_in),
        .aes_mem_we_in      (aes_mem_we_in),
        .aes_mem_rd_addr_in (aes_mem_rd_addr_in),
        .aes_mem_wr_addr_in (aes_mem_wr_addr_in),
        .aes_data_out       (aes_data_out),
        .aes_complete_out   (aes_complete_out)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     sb_q [$];
    logic [31:0] mem_model [1024];
    logic [7:0]  sbox_tb [256];
    logic        rd_req  = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (GF arithmetic, full key schedule) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int i = 0; i < 4; i++)  w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tb[tmp[23:16]], sbox_tb[tmp[15:8]], sbox_tb[tmp[7:0]], sbox_tb[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_tb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = t[4*((c+r)%4)+r];
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- monitor: pops one expectation per presented read ----------------
    always @(posedge clk_in) rd_pend <= rd_req;

    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk_in);
            if (rd_pend) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected got=%h exp=none", aes_data_out);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("rd[%0d]", e.addr), aes_data_out, e.exp);
                end
            end
        end
    end

    // ---------------- driver tasks (entered just after a falling edge) ----------------
    task automatic set_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        aes_mem_wr_addr_in = a;
        aes_data_in        = d;
        aes_mem_we_in      = be;
        for (int i = 0; i < 4; i++)
            if (be[i]) mem_model[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        set_write(a, d, be);
        @(negedge clk_in);
        aes_mem_we_in = 4'h0;
    endtask

    task automatic rd(input logic [9:0] a);
        aes_mem_rd_addr_in = a;
        rd_req = 1'b1;
        sb_q.push_back('{addr: a, exp: mem_model[a]});
        @(negedge clk_in);
        rd_req = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic encrypt(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp_ct, input bit hold, input bit poke);
        int cyc;
        for (int i = 0; i < 4; i++) wr(10'(i), pt[127-32*i -: 32], 4'hf);
        for (int i = 0; i < 4; i++) wr(10'(4 + i), key[127-32*i -: 32], 4'hf);
        aes_ctrl_in = 3'b001;
        @(negedge clk_in);
        if (!hold) aes_ctrl_in = 3'($urandom_range(2, 7));
        cyc = 0;
        while (!aes_complete_out && cyc < 60) begin
            @(negedge clk_in);
            cyc++;
            aes_mem_we_in = 4'h0;
            if (poke && cyc == 12) set_write(10'($urandom_range(0, 7)), $urandom, 4'hf);
            if (poke && cyc == 20) set_write(10'd256, $urandom, 4'hf);
        end
        aes_mem_we_in = 4'h0;
        check({tag, "_latency"}, 32'(cyc), 32'd25);
        for (int i = 0; i < 4; i++) mem_model[256 + i] = exp_ct[127-32*i -: 32];
        repeat (hold ? 5 : 1) @(negedge clk_in);
        check({tag, "_complete_held"}, 32'(aes_complete_out), 32'd1);
        aes_ctrl_in = 3'b000;
        @(negedge clk_in);
        check({tag, "_complete_ack"}, 32'(aes_complete_out), 32'd0);
        for (int i = 0; i < 4; i++) rd(10'(256 + i));
        for (int i = 0; i < 8; i++) rd(10'(i));
        rd(10'd260);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] FIPS_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] SP_PT    = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
    localparam logic [127:0] SP_KEY   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] SP_CT    = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;

    initial begin
        logic [7:0]   inv;
        logic [127:0] rpt, rkey;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_in             = 1'b1;
        aes_ctrl_in        = 3'b000;
        aes_data_in        = '0;
        aes_mem_we_in      = 4'h0;
        aes_mem_rd_addr_in = '0;
        aes_mem_wr_addr_in = '0;
        repeat (2) @(negedge clk_in);
        check("reset_complete", 32'(aes_complete_out), 32'd0);
        check("reset_data_out", aes_data_out, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 6; i++) wr(10'(i), $urandom, 4'hf);
        for (int i = 0; i < 6; i++) rd(10'(i));

        wr(10'd9, 32'hdeadbeef, 4'hf);
        wr(10'd9, 32'h00000000, 4'b0101);
        rd(10'd9);
        wr(10'd260, $urandom, 4'hf);

        encrypt("fips", FIPS_PT, FIPS_KEY, FIPS_CT, 1'b1, 1'b0);
        encrypt("fips_rerun", FIPS_PT, FIPS_KEY, FIPS_CT, 1'b0, 1'b1);
        encrypt("sp800", SP_PT, SP_KEY, SP_CT, 1'b0, 1'b1);

        // Abort a run mid-ROUND, confirm it never resumes, then run again.
        for (int i = 0; i < 4; i++) wr(10'(i), FIPS_PT[127-32*i -: 32], 4'hf);
        for (int i = 0; i < 4; i++) wr(10'(4 + i), FIPS_KEY[127-32*i -: 32], 4'hf);
        aes_ctrl_in = 3'b001;
        @(negedge clk_in);
        aes_ctrl_in = 3'b000;
        repeat (14) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("midrun_rst_complete", 32'(aes_complete_out), 32'd0);
        check("midrun_rst_data_out", aes_data_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (30) @(negedge clk_in);
        check("after_abort_idle", 32'(aes_complete_out), 32'd0);
        rd(10'd9);
        encrypt("post_reset", SP_PT, SP_KEY, SP_CT, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            encrypt($sformatf("rand%0d", n), rpt, rkey, aes_model(rpt, rkey),
                    1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) @(negedge clk_in);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
